dsp_mac_sequencer: RTL and testbench

Controller that sequences the DSP48A1-style multiply-accumulate slice through an N-sample dot product. Accepts a start command carrying the sample count and mode, and clears the P accumulator. Streams operand pairs in under a valid/ready handshake and drives the slice's clock enables, P reset and OPMODE. Pulses `done` once the final sum is present on the slice's P output. Sits between the sample-source logic and one DSP slice instance.

---
 rtl/dsp_seq_pkg.sv | 19 +
 rtl/register.sv | 29 ++
 rtl/dsp_mac_sequencer.sv | 111 +++++++++++
 tb/tb_dsp_mac_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP MAC sequencer.
package dsp_seq_pkg;

   localparam int unsigned OPMODE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // X = M, Z = P, post-adder add
   localparam logic [OPMODE_W-1:0] OPMODE_MAC  = 8'h09;
   // Same routing with the post-adder subtracting
   localparam logic [OPMODE_W-1:0] OPMODE_MSUB = 8'h89;

endpackage

// File: rtl/register.sv
// Generic enabled register with selectable async or sync active-high reset.
module register #(
   parameter int unsigned WIDTH   = 1,
   parameter string       RSTTYPE = "ASYNC"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (RSTTYPE == "ASYNC") begin : g_async
         // Asynchronous reset flop
         always_ff @(posedge clk or posedge rst) begin
            if (rst)     q <= '0;
            else if (ce) q <= d;
         end
      end else begin : g_sync
         // Synchronous reset flop
         always_ff @(posedge clk) begin
            if (rst)     q <= '0;
            else if (ce) q <= d;
         end
      end
   endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1-style MAC slice through an N-sample dot product.
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int unsigned LEN_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 sub,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 cea,
   output logic                 ceb,
   output logic                 cem,
   output logic                 cep,
   output logic                 rstp,
   output logic [OPMODE_W-1:0]  opmode,
   output logic                 done
);

   state_t               state, state_next;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] cnt;
   logic [LEN_WIDTH-1:0] cnt_inc;
   logic                 sub_q;
   logic                 accept;
   logic                 d1, d2;

   assign cnt_inc = LEN_WIDTH'(cnt + 1'b1);

   // State, run parameters and accept counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         len_q <= '0;
         sub_q <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && start && len != '0) begin
            len_q <= len;
            sub_q <= sub;
            cnt   <= '0;
         end else if (accept) begin
            cnt <= cnt_inc;
         end
      end
   end

   // Next-state and control decode
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      rstp       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start && len != '0) state_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            rstp       = 1'b1;
            state_next = ST_ACCUM;
         end
         ST_ACCUM: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (accept && cnt_inc == len_q) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Last product is being enabled into P this cycle
            if (d2 && !d1) state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Operand registers load in the same cycle as the handshake
   assign cea    = accept;
   assign ceb    = accept;
   assign cem    = d1;
   assign cep    = d2;
   assign opmode = sub_q ? OPMODE_MSUB : OPMODE_MAC;

   // Accept delay line: M enable one cycle later, P enable two cycles later
   register #(.WIDTH(1), .RSTTYPE("ASYNC")) u_d1 (
      .clk (clk),
      .rst (rst),
      .ce  (1'b1),
      .d   (accept),
      .q   (d1)
   );

   register #(.WIDTH(1), .RSTTYPE("ASYNC")) u_d2 (
      .clk (clk),
      .rst (rst),
      .ce  (1'b1),
      .d   (d1),
      .q   (d2)
   );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice model.
module tb_dsp_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        sub;
   logic        in_valid;
   logic        in_ready;
   logic        busy;
   logic        cea, ceb, cem, cep, rstp;
   logic [7:0]  opmode;
   logic        done;

   logic signed [17:0] a, b;
   logic signed [17:0] a_r = '0, b_r = '0;
   logic signed [35:0] m_r = '0;
   logic signed [47:0] p_r = '0;

   longint cyc      = 0;
   longint last_acc = 0;
   int     acc_cnt  = 0;
   int     cem_cnt  = 0;
   int     cep_cnt  = 0;

   int errors = 0;
   int checks = 0;

   int pa [0:2047];
   int pb [0:2047];
   bit pv [0:2047];

   logic [47:0] sbq [$];

   dsp_mac_sequencer #(.LEN_WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .sub      (sub),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .busy     (busy),
      .cea      (cea),
      .ceb      (ceb),
      .cem      (cem),
      .cep      (cep),
      .rstp     (rstp),
      .opmode   (opmode),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Slice model plus pulse/accept bookkeeping
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cea) a_r <= a;
      if (ceb) b_r <= b;
      if (cem) m_r <= a_r * b_r;
      if (rstp)     p_r <= '0;
      else if (cep) p_r <= opmode[7] ? p_r - {{12{m_r[35]}}, m_r}
                                     : p_r + {{12{m_r[35]}}, m_r};
      if (in_valid && in_ready) begin
         acc_cnt  <= acc_cnt + 1;
         last_acc <= cyc;
      end
      if (cem) cem_cnt <= cem_cnt + 1;
      if (cep) cep_cnt <= cep_cnt + 1;
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_all_valid();
      for (int i = 0; i < 2048; i++) pv[i] = 1'b1;
   endtask

   // One complete run: start, stream, wait for done, compare, end in first IDLE cycle
   task automatic run(input int n, input bit sb, input bit hold, input int poke);
      longint exp_sum;
      longint start_cyc;
      int     idx, k, w;
      int     acc0, cem0, cep0;
      bit     acc;
      logic [7:0] op_exp;

      op_exp  = sb ? 8'h89 : 8'h09;
      exp_sum = 0;
      for (int i = 0; i < n; i++) exp_sum += longint'(pa[i]) * longint'(pb[i]);
      if (sb) exp_sum = -exp_sum;
      sbq.push_back(48'(exp_sum));
      acc0 = acc_cnt; cem0 = cem_cnt; cep0 = cep_cnt;

      start_cyc = cyc;
      start = 1'b1; len = 8'(n); sub = sb;
      @(posedge clk); #1;
      start = 1'b0; len = 8'd0; sub = 1'b0;
      chk("clear_rstp", 48'(rstp), 48'd1);
      chk("clear_in_ready", 48'(in_ready), 48'd0);
      chk("clear_busy", 48'(busy), 48'd1);
      chk("clear_opmode", 48'(opmode), 48'(op_exp));
      @(posedge clk); #1;
      chk("accum_rstp", 48'(rstp), 48'd0);
      chk("accum_in_ready", 48'(in_ready), 48'd1);

      idx = 0; k = 0;
      while (idx < n && k < 2000) begin
         in_valid = pv[k];
         if (pv[k]) begin a = 18'(pa[idx]); b = 18'(pb[idx]); end
         else       begin a = 18'd55;       b = 18'd77;       end
         if (k == poke) begin start = 1'b1; len = 8'd3; sub = !sb; end
         else           begin start = 1'b0; end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         k++;
         chk("run_opmode", 48'(opmode), 48'(op_exp));
      end
      if (idx < n) chk("stream_timeout", 48'(idx), 48'(n));
      start = 1'b0; len = 8'd0; sub = 1'b0;
      in_valid = hold; a = 18'd99; b = 18'd99;

      w = 0;
      while (!done && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      if (done) begin
         chk("result_p", p_r, sbq.pop_front());
         chk("done_latency", 48'(cyc - last_acc), 48'd3);
         chk("accept_count", 48'(acc_cnt - acc0), 48'(n));
         chk("cem_count", 48'(cem_cnt - cem0), 48'(n));
         chk("cep_count", 48'(cep_cnt - cep0), 48'(n));
         chk("done_opmode", 48'(opmode), 48'(op_exp));
         if (n == 1 && pv[0]) chk("min_run_latency", 48'(cyc - start_cyc), 48'd5);
      end else begin
         chk("done_timeout", 48'(done), 48'd1);
         void'(sbq.pop_front());
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_done_pulse", 48'(done), 48'd0);
      chk("post_busy", 48'(busy), 48'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = 8'd0; sub = 1'b0; in_valid = 1'b0;
      a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 48'(in_ready), 48'd0);
      chk("rst_busy", 48'(busy), 48'd0);
      chk("rst_cea", 48'(cea), 48'd0);
      chk("rst_ceb", 48'(ceb), 48'd0);
      chk("rst_cem", 48'(cem), 48'd0);
      chk("rst_cep", 48'(cep), 48'd0);
      chk("rst_rstp", 48'(rstp), 48'd0);
      chk("rst_done", 48'(done), 48'd0);
      chk("rst_opmode", 48'(opmode), 48'h09);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Abort a subtract run after two accepts with an async reset
      start = 1'b1; len = 8'd4; sub = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; len = 8'd0; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; a = 18'd1; b = 18'd1;
      @(posedge clk); #1;
      a = 18'd2; b = 18'd2;
      @(posedge clk); #1;
      chk("pre_rst_cea", 48'(cea), 48'd1);
      chk("pre_rst_cep", 48'(cep), 48'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 48'(busy), 48'd0);
      chk("arst_in_ready", 48'(in_ready), 48'd0);
      chk("arst_cea", 48'(cea), 48'd0);
      chk("arst_ceb", 48'(ceb), 48'd0);
      chk("arst_cem", 48'(cem), 48'd0);
      chk("arst_cep", 48'(cep), 48'd0);
      chk("arst_rstp", 48'(rstp), 48'd0);
      chk("arst_done", 48'(done), 48'd0);
      chk("arst_opmode", 48'(opmode), 48'h09);
      in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Continuous MAC run: 1*2+3*4+5*6+7*8 = 100
      set_all_valid();
      pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4;
      pa[2] = 5; pb[2] = 6; pa[3] = 7; pb[3] = 8;
      run(4, 1'b0, 1'b1, -1);

      // Gapped stream: 4+9+16 = 29
      for (int i = 0; i < 2048; i++) pv[i] = 1'b0;
      pv[0] = 1'b1; pv[3] = 1'b1; pv[5] = 1'b1;
      pa[0] = 2; pb[0] = 2; pa[1] = 3; pb[1] = 3; pa[2] = 4; pb[2] = 4;
      run(3, 1'b0, 1'b0, -1);

      // Subtract: -(25+6) = -31
      set_all_valid();
      pa[0] = 5; pb[0] = 5; pa[1] = 2; pb[1] = 3;
      run(2, 1'b1, 1'b0, -1);

      // Zero-length start is ignored
      start = 1'b1; len = 8'd0; sub = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; sub = 1'b0;
      chk("len0_busy", 48'(busy), 48'd0);
      chk("len0_rstp", 48'(rstp), 48'd0);
      @(posedge clk); #1;
      chk("len0_busy2", 48'(busy), 48'd0);
      chk("len0_done", 48'(done), 48'd0);

      // Maximum-length run with a stray start mid-stream, then back-to-back min run
      for (int i = 0; i < 255; i++) begin
         pa[i] = (i % 7) + 1;
         pb[i] = (i % 5) - 2;
      end
      run(255, 1'b0, 1'b1, 20);
      pa[0] = -9; pb[0] = 11;
      run(1, 1'b0, 1'b1, -1);
      pa[0] = 300; pb[0] = -4;
      run(1, 1'b1, 1'b0, -1);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
